// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light safety monitor: light codes, lamp
// encodings, fault codes and the monitor state enum.
package tlc_pkg;

  localparam logic [1:0] CODE_GREEN  = 2'b00;
  localparam logic [1:0] CODE_YELLOW = 2'b01;
  localparam logic [1:0] CODE_RED    = 2'b10;
  localparam logic [1:0] CODE_REDYEL = 2'b11;

  localparam logic [2:0] LAMP_OFF    = 3'b000;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_REDYEL = 3'b110;

  localparam logic [1:0] FC_NONE     = 2'b00;
  localparam logic [1:0] FC_CONFLICT = 2'b01;
  localparam logic [1:0] FC_STUCK    = 2'b10;

  localparam logic PHASE_ON = 1'b1;

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'd0,
    ST_SUSPECT  = 2'd1,
    ST_FAILSAFE = 2'd2
  } mon_state_t;

  function automatic logic [2:0] lamp_of(input logic [1:0] code);
    logic [2:0] lamp;
    case (code)
      CODE_GREEN:  lamp = LAMP_GREEN;
      CODE_YELLOW: lamp = LAMP_YELLOW;
      CODE_RED:    lamp = LAMP_RED;
      default:     lamp = LAMP_REDYEL;
    endcase
    return lamp;
  endfunction

endpackage

// File: rtl/tlc_blink_gen.sv
// Fail-safe blink phase generator. The phase output is the value the phase
// flop takes at the coming edge, so the caller can register lamps without lag.
module tlc_blink_gen
  import tlc_pkg::*;
#(
  parameter int BLINK_HALF = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  output logic phase
);

  logic [7:0] cnt;
  logic       phase_q;
  logic       wrap;

  assign wrap = (cnt == 8'(BLINK_HALF - 1));

  always_comb begin
    phase = phase_q;
    if (clear) phase = PHASE_ON;
    else if (enable && wrap) phase = ~phase_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt     <= 8'd0;
      phase_q <= PHASE_ON;
    end else if (clear) begin
      cnt     <= 8'd0;
      phase_q <= PHASE_ON;
    end else if (enable) begin
      if (wrap) begin
        cnt     <= 8'd0;
        phase_q <= ~phase_q;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/traffic_light_safety_monitor.sv
// Traffic light safety monitor: latches a fail-safe blink on conflicting greens
// or (with TLC_MONITOR_STUCK_EN defined) on controller codes frozen while GO=1.
module traffic_light_safety_monitor
  import tlc_pkg::*;
#(
  parameter int CONFLICT_CYCLES = 2,
  parameter int STUCK_LIMIT     = 64,
  parameter int BLINK_HALF      = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       GO,
  input  logic [1:0] HS1,
  input  logic [1:0] HS2,
  input  logic [1:0] FS1,
  input  logic [1:0] FS2,
  output logic [2:0] HS1_LAMP,
  output logic [2:0] HS2_LAMP,
  output logic [2:0] FS1_LAMP,
  output logic [2:0] FS2_LAMP,
  output logic       FAULT,
  output logic [1:0] FAULT_CODE,
  output logic [1:0] STATE
);

  mon_state_t state;
  logic [3:0] conf_cnt;
  logic       conflict, conflict_trip, stuck_trip;
  logic       in_fs, enter_fs, blink_phase;

  assign conflict = ((HS1 != CODE_RED) || (HS2 != CODE_RED)) &&
                    ((FS1 != CODE_RED) || (FS2 != CODE_RED));
  assign conflict_trip = conflict && (conf_cnt == 4'(CONFLICT_CYCLES - 1));
  assign in_fs    = (state == ST_FAILSAFE);
  assign enter_fs = !in_fs && (conflict_trip || stuck_trip);
  assign STATE    = state;

`ifdef TLC_MONITOR_STUCK_EN
  localparam int SW = $clog2(STUCK_LIMIT + 1);
  logic [7:0]    prev_codes;
  logic [SW-1:0] stuck_cnt;
  logic          same;

  assign same       = ({HS1, HS2, FS1, FS2} == prev_codes);
  assign stuck_trip = GO && same && (stuck_cnt == SW'(STUCK_LIMIT - 1));

  always_ff @(posedge CLK) begin
    if (RST) begin
      prev_codes <= {4{CODE_RED}};
      stuck_cnt  <= '0;
    end else begin
      prev_codes <= {HS1, HS2, FS1, FS2};
      if (!same) stuck_cnt <= '0;
      else if (GO && (stuck_cnt != SW'(STUCK_LIMIT))) stuck_cnt <= stuck_cnt + SW'(1);
    end
  end
`else
  logic unused_go;
  assign unused_go  = GO;
  assign stuck_trip = 1'b0;
`endif

  tlc_blink_gen #(.BLINK_HALF(BLINK_HALF)) u_blink (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (enter_fs),
    .enable (in_fs),
    .phase  (blink_phase)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_NORMAL;
      conf_cnt   <= 4'd0;
      FAULT      <= 1'b0;
      FAULT_CODE <= FC_NONE;
      HS1_LAMP   <= LAMP_RED;
      HS2_LAMP   <= LAMP_RED;
      FS1_LAMP   <= LAMP_RED;
      FS2_LAMP   <= LAMP_RED;
    end else begin
      if (in_fs) begin
        conf_cnt <= 4'd0;
      end else if (enter_fs) begin
        state      <= ST_FAILSAFE;
        conf_cnt   <= 4'd0;
        FAULT      <= 1'b1;
        // Conflict wins when both watchdogs trip on the same edge.
        FAULT_CODE <= conflict_trip ? FC_CONFLICT : FC_STUCK;
      end else begin
        state    <= conflict ? ST_SUSPECT : ST_NORMAL;
        conf_cnt <= conflict ? conf_cnt + 4'd1 : 4'd0;
      end

      if (in_fs || enter_fs) begin
        HS1_LAMP <= blink_phase ? LAMP_YELLOW : LAMP_OFF;
        HS2_LAMP <= blink_phase ? LAMP_YELLOW : LAMP_OFF;
        FS1_LAMP <= blink_phase ? LAMP_RED : LAMP_OFF;
        FS2_LAMP <= blink_phase ? LAMP_RED : LAMP_OFF;
      end else begin
        HS1_LAMP <= lamp_of(HS1);
        HS2_LAMP <= lamp_of(HS2);
        FS1_LAMP <= lamp_of(FS1);
        FS2_LAMP <= lamp_of(FS2);
      end
    end
  end

endmodule

// File: doc/traffic_light_safety_monitor.md
TRAFFIC_LIGHT_SAFETY_MONITOR -- requirements
Module: traffic_light_safety_monitor

Interface
REQ-001 Parameter CONFLICT_CYCLES, default 2: consecutive conflict cycles that trip fail-safe (range 1..15).
REQ-002 Parameter STUCK_LIMIT, default 64: unchanged-input cycles with GO=1 that trip fail-safe; must exceed the longest controller dwell (31).
REQ-003 Parameter BLINK_HALF, default 4: cycles per fail-safe blink half-period (range 1..255).
REQ-004 CLK  input  1  single clock; all state changes on rising edge.
REQ-005 RST  input  1  reset, synchronous and active-high.
REQ-006 GO  input  1  controller run enable; 0 freezes the stuck watchdog.
REQ-007 HS1, HS2, FS1, FS2  input  2 each  light codes from the traffic controller: red=10, green=00, yellow=01, redyellow=11.
REQ-008 HS1_LAMP, HS2_LAMP, FS1_LAMP, FS2_LAMP  output  3 each  lamp drives {R,Y,G}, registered.
REQ-009 FAULT  output  1  registered; 1 while in FAILSAFE.
REQ-010 FAULT_CODE  output  2  registered; 00 none, 01 conflict, 10 stuck.

Function
REQ-011 The monitor SHALL implement states NORMAL, SUSPECT, FAILSAFE.
REQ-012 Conflict SHALL be: (HS1!=red or HS2!=red) and (FS1!=red or FS2!=red), evaluated each cycle.
REQ-013 Conflict counter: +1 on each conflict cycle, cleared on any non-conflict cycle; NORMAL->SUSPECT on first conflict, SUSPECT->NORMAL on non-conflict.
REQ-014 The edge that samples the CONFLICT_CYCLES-th consecutive conflict SHALL enter FAILSAFE with FAULT_CODE=01.
REQ-015 Stuck counter: +1 when GO=1 and all four codes equal the previous cycle's; 0 on any code change; held when GO=0; saturates at STUCK_LIMIT.
REQ-016 The edge on which the stuck counter reaches STUCK_LIMIT SHALL enter FAILSAFE with FAULT_CODE=10.
REQ-017 Simultaneous conflict and stuck trip on one edge SHALL record FAULT_CODE=01.
REQ-018 FAILSAFE SHALL be latched; only RST exits it; FAULT_CODE holds the first cause.
REQ-019 Outside FAILSAFE, lamps SHALL mirror inputs sampled at the previous edge (1-cycle latency): red->100, yellow->010, green->001, redyellow->110.
REQ-020 In SUSPECT, lamps SHALL still mirror inputs (no masking before trip).
REQ-021 On the FAILSAFE entry edge, blink counter SHALL clear and phase SHALL be ON; phase toggles every BLINK_HALF cycles.
REQ-022 FAILSAFE phase ON: HS lamps 010, FS lamps 100; phase OFF: all lamps 000.
REQ-023 Undefined/X input codes are not handled; codes are always one of the four values.

Reset
REQ-024 On RST=1 at an edge: state NORMAL, both counters 0, blink phase ON, previous-code register = all red.
REQ-025 Reset output values: all lamps 100, FAULT=0, FAULT_CODE=00.
REQ-026 RST asserted in FAILSAFE SHALL return to NORMAL at that edge; monitoring resumes the next cycle.

Configuration
REQ-027 Macro TLC_MONITOR_STUCK_EN: when defined, the stuck watchdog (REQ-015/016) is present.
REQ-028 Without TLC_MONITOR_STUCK_EN, no stuck counter is built; FAULT_CODE=10 never occurs; GO is unused.

Structure
REQ-029 Shared package tlc_pkg SHALL hold light codes, lamp encodings, FAULT_CODE values and the monitor state enum.
REQ-030 Sub-module tlc_blink_gen (clear, enable, BLINK_HALF -> phase) SHALL generate the blink phase.

Verification
REQ-031 Normal sequence HS=00/00, FS=10/10 -> next cycle HS lamps 001, FS lamps 100, FAULT=0.
REQ-032 One conflict cycle (HS1=00, FS1=00) then clean, CONFLICT_CYCLES=2 -> SUSPECT then NORMAL, FAULT=0.
REQ-033 Two conflict cycles -> FAULT=1, FAULT_CODE=01 at 2nd edge; HS lamps 010 for 4 cycles, then 000 for 4, repeating.
REQ-034 Stuck test (macro on): codes frozen, GO=1 for 64 cycles -> FAULT_CODE=10; with GO=0 for 100 cycles -> no fault.
REQ-035 Conflict and stuck on the same edge -> FAULT_CODE=01.
REQ-036 RST=1 for 1 cycle in FAILSAFE -> FAULT=0, lamps 100, state NORMAL.
